// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared sizes and FSM state encoding for mem_arbiter
// Purpose: memory geometry (byte-wide RAM, 16-bit words) and the access FSM states.
// Ports: none (package).
package mem_arbiter_pkg;

  localparam int MEM_DEPTH  = 2048;
  localparam int MEM_WIDTH  = 8;
  localparam int WORD_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ACC0 = 3'd1,
    ACC1 = 3'd2,
    ACC2 = 3'd3,
    ERR  = 3'd4,
    DONE = 3'd5
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin winner select for mem_arbiter
// Purpose: pick the first requesting port after last_winner, wrapping around.
// Ports:
//   req         in   NPORTS  per-port request
//   last_winner in   IW      port granted most recently
//   grant       out  NPORTS  one-hot winner (all zero when no request)
//   grant_id    out  IW      winner index
//   grant_valid out  1       at least one request present
module rr_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NPORTS = 3,
  parameter int IW     = 2
) (
  input  logic [NPORTS-1:0] req,
  input  logic [IW-1:0]     last_winner,
  output logic [NPORTS-1:0] grant,
  output logic [IW-1:0]     grant_id,
  output logic              grant_valid
);

  logic [IW-1:0] lo_id;
  logic [IW-1:0] hi_id;
  logic          hi_found;

  // Scanning downwards leaves the lowest matching index in each candidate:
  // hi_id is the first requester above last_winner, lo_id the wrap-around one.
  always_comb begin
    lo_id    = '0;
    hi_id    = '0;
    hi_found = 1'b0;
    for (int i = NPORTS - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_id = IW'(i);
      end
      if (req[i] && (i > int'(last_winner))) begin
        hi_id    = IW'(i);
        hi_found = 1'b1;
      end
    end
    grant_id    = hi_found ? hi_id : lo_id;
    grant_valid = |req;
    grant       = grant_valid ? (NPORTS'(1) << grant_id) : '0;
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - serializes 16-bit word accesses from NPORTS ports onto one byte RAM
// Purpose: round-robin arbiter plus access FSM; each word is two byte accesses,
//          low byte at the even base address, high byte at base+1.
// Ports:
//   clock, nrst          clock and synchronous active-low reset
//   req/we               per-port request level and write enable
//   addr_in/wdata_in     per-port 16-bit byte address and write word
//   ack/err/rdata        one-cycle completion pulse, out-of-range flag, read word
//   busy                 high whenever the FSM is not IDLE
//   mem_addr/mem_we/mem_wdata/mem_rdata  single-port RAM, 1-cycle read latency
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NPORTS = 3,
  parameter int AW     = $clog2(MEM_DEPTH)
) (
  input  logic                         clock,
  input  logic                         nrst,
  input  logic [NPORTS-1:0]            req,
  input  logic [NPORTS-1:0]            we,
  input  logic [WORD_WIDTH*NPORTS-1:0] addr_in,
  input  logic [WORD_WIDTH*NPORTS-1:0] wdata_in,
  output logic [NPORTS-1:0]            ack,
  output logic                         err,
  output logic [WORD_WIDTH-1:0]        rdata,
  output logic                         busy,
  output logic [AW-1:0]                mem_addr,
  output logic                         mem_we,
  output logic [MEM_WIDTH-1:0]         mem_wdata,
  input  logic [MEM_WIDTH-1:0]         mem_rdata
);

  localparam int IW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  state_t                state, state_next;
  logic [IW-1:0]         last_winner;
  logic [IW-1:0]         id_q;
  logic                  we_q;
  logic                  err_q;
  logic [AW-1:0]         base_q;
  logic [WORD_WIDTH-1:0] wdata_q;

  logic [NPORTS-1:0]     grant;
  logic [IW-1:0]         grant_id;
  logic                  grant_valid;
  logic [WORD_WIDTH-1:0] sel_addr;
  logic [WORD_WIDTH-1:0] sel_wdata;
  logic                  sel_we;
  logic                  sel_oob;
  logic                  unused_addr_lsb;

  rr_arbiter #(
    .NPORTS(NPORTS),
    .IW    (IW)
  ) u_rr (
    .req        (req),
    .last_winner(last_winner),
    .grant      (grant),
    .grant_id   (grant_id),
    .grant_valid(grant_valid)
  );

  // Operand mux driven by the one-hot grant.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int i = 0; i < NPORTS; i++) begin
      if (grant[i]) begin
        sel_addr  = addr_in[WORD_WIDTH*i +: WORD_WIDTH];
        sel_wdata = wdata_in[WORD_WIDTH*i +: WORD_WIDTH];
        sel_we    = we[i];
      end
    end
  end

  // Any address bit at or above AW means the word lies outside the RAM.
  assign sel_oob         = (sel_addr >> AW) != '0;
  // Words are always even-aligned, so the requester's bit 0 is ignored.
  assign unused_addr_lsb = sel_addr[0];

  always_ff @(posedge clock) begin
    if (!nrst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    ack        = '0;
    err        = 1'b0;
    mem_addr   = '0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          state_next = sel_oob ? ERR : ACC0;
        end
      end
      ACC0: begin
        mem_addr   = base_q;
        mem_we     = we_q;
        mem_wdata  = wdata_q[7:0];
        state_next = ACC1;
      end
      ACC1: begin
        mem_addr   = base_q | AW'(1);
        mem_we     = we_q;
        mem_wdata  = wdata_q[15:8];
        state_next = we_q ? DONE : ACC2;
      end
      ACC2: state_next = DONE;
      ERR:  state_next = DONE;
      DONE: begin
        ack        = NPORTS'(1) << id_q;
        err        = err_q;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Operands are captured only at grant so requester-side changes during an
  // access are invisible. Read bytes arrive one cycle after their address:
  // the low byte is on mem_rdata in ACC1, the high byte in ACC2.
  always_ff @(posedge clock) begin
    if (!nrst) begin
      last_winner <= IW'(NPORTS - 1);
      id_q        <= '0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      base_q      <= '0;
      wdata_q     <= '0;
      rdata       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            last_winner <= grant_id;
            id_q        <= grant_id;
            we_q        <= sel_we;
            base_q      <= {sel_addr[AW-1:1], 1'b0};
            wdata_q     <= sel_wdata;
          end
        end
        ACC1: begin
          if (!we_q) begin
            rdata[7:0] <= mem_rdata;
          end
        end
        ACC2: rdata[15:8] <= mem_rdata;
        ERR: begin
          rdata <= '0;
          err_q <= 1'b1;
        end
        DONE: err_q <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with transaction-level model
module tb_mem_arbiter;

  localparam int NPORTS = 3;
  localparam int AW     = 11;
  localparam int DEPTH  = 2048;

  logic                 clock = 1'b0;
  logic                 nrst;
  logic [NPORTS-1:0]    req;
  logic [NPORTS-1:0]    we;
  logic [16*NPORTS-1:0] addr_in;
  logic [16*NPORTS-1:0] wdata_in;
  logic [NPORTS-1:0]    ack;
  logic                 err;
  logic [15:0]          rdata;
  logic                 busy;
  logic [AW-1:0]        mem_addr;
  logic                 mem_we;
  logic [7:0]           mem_wdata;
  logic [7:0]           mem_rdata;

  always #5 clock = ~clock;

  mem_arbiter #(.NPORTS(NPORTS), .AW(AW)) dut (
    .clock    (clock),
    .nrst     (nrst),
    .req      (req),
    .we       (we),
    .addr_in  (addr_in),
    .wdata_in (wdata_in),
    .ack      (ack),
    .err      (err),
    .rdata    (rdata),
    .busy     (busy),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Byte RAM with synchronous read.
  logic [7:0] ram [0:DEPTH-1];
  bit ram_clear = 1'b1;
  always @(posedge clock) begin
    if (ram_clear) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= 8'h00;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  int cyc = 0;
  initial forever begin
    @(posedge clock);
    cyc++;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  typedef struct {
    int          port;
    int          cyc;
    bit          is_err;
    bit          is_read;
    logic [15:0] rdata;
    int          we_pulses;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: word memory, rotation pointer, arbiter free time.
  logic [15:0] ref_mem [0:DEPTH/2-1];
  int          rr_last   = NPORTS - 1;
  int          next_free = 0;
  bit          pend    [NPORTS];
  bit          granted [NPORTS];
  int          grant_cyc [NPORTS];
  int          ack_at  [NPORTS];
  bit          p_we    [NPORTS];
  logic [15:0] p_addr  [NPORTS];
  logic [15:0] p_wdata [NPORTS];

  int          ack_log[$];
  logic [15:0] last_rdata;
  logic        last_err;

  // Monitor: consumes expected completions whenever the DUT acks.
  int we_cnt = 0;
  initial forever begin
    @(negedge clock);
    if (!nrst) begin
      we_cnt = 0;
    end else begin
      if (mem_we) we_cnt++;
      if (ack != '0) begin
        int pn;
        pn = -1;
        for (int i = NPORTS - 1; i >= 0; i--) if (ack[i]) pn = i;
        ack_log.push_back(pn);
        last_rdata = rdata;
        last_err   = err;
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", 32'(ack), 32'h0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("ack_port", 32'(ack), 32'(1) << e.port);
          chk("ack_cycle", 32'(cyc), 32'(e.cyc));
          chk("ack_err", 32'(err), 32'(e.is_err));
          if (e.is_read || e.is_err) chk("ack_rdata", 32'(rdata), 32'(e.rdata));
          chk("we_pulses", 32'(we_cnt), 32'(e.we_pulses));
        end
        we_cnt = 0;
      end else if (err) begin
        chk("err_without_ack", 32'(err), 32'h0);
      end
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        chk("ack_missing_port", 32'hFFFF_FFFF, 32'(exp_q[0].port));
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic drive();
    for (int i = 0; i < NPORTS; i++) begin
      req[i]                = pend[i];
      we[i]                 = p_we[i];
      addr_in[16*i +: 16]   = p_addr[i];
      wdata_in[16*i +: 16]  = p_wdata[i];
    end
  endtask

  task automatic issue(input int p, input bit w, input logic [15:0] a, input logic [15:0] d);
    pend[p]    = 1'b1;
    granted[p] = 1'b0;
    p_we[p]    = w;
    p_addr[p]  = a;
    p_wdata[p] = d;
  endtask

  // One model cycle: requesters drop on their ack, granted requesters
  // scramble their inputs, and an idle arbiter grants the next port in rotation.
  task automatic step();
    int win;
    for (int p = 0; p < NPORTS; p++) begin
      if (granted[p] && ack_at[p] == cyc) begin
        pend[p]    = 1'b0;
        granted[p] = 1'b0;
      end else if (granted[p] && cyc > grant_cyc[p]) begin
        p_addr[p]  = 16'($urandom);
        p_wdata[p] = 16'($urandom);
        p_we[p]    = 1'($urandom);
      end
    end
    win = -1;
    if (cyc >= next_free) begin
      for (int k = 1; k <= NPORTS; k++) begin
        int p;
        p = (rr_last + k) % NPORTS;
        if (win < 0 && pend[p] && !granted[p]) win = p;
      end
    end
    if (win >= 0) begin
      exp_t e;
      bit   oob;
      int   widx;
      int   lat;
      oob  = int'(p_addr[win]) >= DEPTH;
      widx = (int'(p_addr[win]) % DEPTH) / 2;
      lat  = oob ? 2 : (p_we[win] ? 3 : 4);
      e.port      = win;
      e.cyc       = cyc + lat;
      e.is_err    = oob;
      e.is_read   = !oob && !p_we[win];
      e.rdata     = (oob || p_we[win]) ? 16'h0000 : ref_mem[widx];
      e.we_pulses = (!oob && p_we[win]) ? 2 : 0;
      if (!oob && p_we[win]) ref_mem[widx] = p_wdata[win];
      exp_q.push_back(e);
      rr_last        = win;
      next_free      = cyc + lat + 1;
      granted[win]   = 1'b1;
      grant_cyc[win] = cyc;
      ack_at[win]    = cyc + lat;
    end
    drive();
  endtask

  task automatic run_cycle();
    @(negedge clock);
    #1;
    step();
  endtask

  function automatic bit all_idle();
    bit idle;
    idle = (exp_q.size() == 0);
    for (int p = 0; p < NPORTS; p++) if (pend[p]) idle = 1'b0;
    return idle;
  endfunction

  task automatic drain(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      run_cycle();
      done = all_idle();
    end
    chk(name, 32'(done), 32'h1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bit reissued;
    bit hit;
    for (int i = 0; i < DEPTH / 2; i++) ref_mem[i] = 16'h0000;
    for (int p = 0; p < NPORTS; p++) begin
      pend[p] = 1'b0; granted[p] = 1'b0; p_we[p] = 1'b0;
      p_addr[p] = 16'h0; p_wdata[p] = 16'h0; grant_cyc[p] = 0; ack_at[p] = 0;
    end
    nrst = 1'b0;
    drive();
    repeat (3) @(negedge clock);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_rdata", 32'(rdata), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    #1;
    ram_clear = 1'b0;
    nrst      = 1'b1;

    // Three simultaneous requests: order 0,1,2, then a re-raised port 0.
    issue(0, 1'b0, 16'h0010, 16'h0);
    issue(1, 1'b0, 16'h0020, 16'h0);
    issue(2, 1'b0, 16'h0030, 16'h0);
    reissued = 1'b0;
    for (int n = 0; n < 60; n++) begin
      run_cycle();
      if (!reissued && ack_log.size() >= 1) begin
        issue(0, 1'b0, 16'h0040, 16'h0);
        reissued = 1'b1;
      end
      if (reissued && all_idle()) break;
    end
    chk("rr_count", 32'(ack_log.size()), 32'd4);
    if (ack_log.size() >= 4) begin
      chk("rr_order0", 32'(ack_log[0]), 32'd0);
      chk("rr_order1", 32'(ack_log[1]), 32'd1);
      chk("rr_order2", 32'(ack_log[2]), 32'd2);
      chk("rr_order3", 32'(ack_log[3]), 32'd0);
    end

    // Port 1 writes 0xBEEF to 0x0248, then port 0 reads it back.
    issue(1, 1'b1, 16'h0248, 16'hBEEF);
    drain("drain_write", 40);
    chk("ram_lo", 32'(ram[11'h248]), 32'hEF);
    chk("ram_hi", 32'(ram[11'h249]), 32'hBE);
    issue(0, 1'b0, 16'h0248, 16'h0);
    drain("drain_read", 40);
    chk("read_beef", 32'(last_rdata), 32'hBEEF);

    // Out-of-range read on port 2.
    issue(2, 1'b0, 16'h0900, 16'h0);
    drain("drain_oob", 40);
    chk("oob_err", 32'(last_err), 32'h1);
    chk("oob_rdata", 32'(last_rdata), 32'h0);

    // Reset during ACC1 of a write abandons it silently.
    issue(1, 1'b1, 16'h0300, 16'h1234);
    hit = 1'b0;
    for (int n = 0; n < 20 && !hit; n++) begin
      run_cycle();
      hit = granted[1] && (cyc == grant_cyc[1] + 2);
    end
    chk("reach_acc1", 32'(hit), 32'h1);
    exp_q.delete();
    for (int p = 0; p < NPORTS; p++) begin
      pend[p] = 1'b0; granted[p] = 1'b0;
    end
    rr_last   = NPORTS - 1;
    next_free = 0;
    drive();
    nrst = 1'b0;
    @(negedge clock);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_ack", 32'(ack), 32'h0);
    chk("midrst_mem_we", 32'(mem_we), 32'h0);
    #1;
    nrst = 1'b1;
    issue(1, 1'b1, 16'h0300, 16'h1234);
    drain("drain_rewrite", 40);
    issue(2, 1'b0, 16'h0301, 16'h0);
    drain("drain_reread", 40);
    chk("reread", 32'(last_rdata), 32'h1234);

    // Randomized traffic over a small window so reads hit earlier writes.
    for (int n = 0; n < 400; n++) begin
      run_cycle();
      for (int p = 0; p < NPORTS; p++) begin
        if (!pend[p] && $urandom_range(0, 99) < 35) begin
          logic [15:0] a;
          if ($urandom_range(0, 99) < 12) a = 16'($urandom_range(16'h0800, 16'hFFFF));
          else if ($urandom_range(0, 99) < 80) a = 16'($urandom_range(0, 63));
          else a = 16'($urandom_range(0, DEPTH - 1));
          issue(p, 1'($urandom), a, 16'($urandom));
        end
      end
    end
    drain("drain_random", 200);
    chk("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
